semaforo_monitor: RTL and testbench

Receive-side checker for the two-lamp traffic-light interface: A[2:0] is the main lamp and B[2:0] is the pedestrian/secondary lamp.
- Lamp codes are one-hot: 001 green, 010 yellow, 100 red.
- The block samples the lamp buses every clk and tracks the main-lamp sequence and dwell times against the controller's timing.
- It raises a sticky fault with a code on any protocol violation and counts completed light cycles.
- It sits beside the controller at the lamp-driver boundary and feeds the board's fault LED and debug display.

---
 rtl/semaforo_monitor_if.sv | 20 ++
 rtl/semaforo_monitor.sv | 180 ++++++++++++++++++
 tb/tb_semaforo_monitor.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/semaforo_monitor_if.sv
// Lamp-boundary bus between the traffic-light controller side and the monitor.
interface semaforo_monitor_if;
  logic [2:0] A;
  logic [2:0] B;
  logic       clr;
  logic       fault;
  logic [2:0] fault_code;
  logic       tracking;
  logic [7:0] cycle_cnt;

  modport master (
    output A, B, clr,
    input  fault, fault_code, tracking, cycle_cnt
  );

  modport slave (
    input  A, B, clr,
    output fault, fault_code, tracking, cycle_cnt
  );
endinterface

// File: rtl/semaforo_monitor.sv
// Receive-side checker for the two-lamp traffic light: follows the main-lamp
// sequence and dwell times, latches the first protocol fault and counts
// completed red->green cycles.
//
// state | meaning
// SYNC  | waiting for a legal main-lamp transition to lock onto
// TRACK | locked; sequence and exact dwell times are checked
// FAULT | sticky fault latched; inputs ignored until clr
module semaforo_monitor #(
  parameter int T_VERDE    = 2,
  parameter int T_AMARELO  = 4,
  parameter int T_VERMELHO = 3,
  parameter int CW         = 4
) (
  input  logic              clk,
  input  logic              rst,
  semaforo_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [2:0]    LAMP_G = 3'b001;
  localparam logic [2:0]    LAMP_Y = 3'b010;
  localparam logic [2:0]    LAMP_R = 3'b100;
  localparam logic [CW-1:0] TV     = CW'(T_VERDE);
  localparam logic [CW-1:0] TA     = CW'(T_AMARELO);
  localparam logic [CW-1:0] TR     = CW'(T_VERMELHO);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t          state_q, state_d;
  logic [2:0]      a_q, a_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fault_q, fault_d;
  logic [2:0]      code_q, code_d;
  logic            tracking_q, tracking_d;
  logic [7:0]      cycle_q, cycle_d;

  logic            a_onehot;
  logic            b_ok;
  logic [2:0]      succ;
  logic [CW-1:0]   t_cur;
  logic            a_changed;
  logic [2:0]      viol;

  // Decode lamp legality, the expected successor and the dwell for a_q.
  always_comb begin
    a_onehot  = (bus.A == LAMP_G) || (bus.A == LAMP_Y) || (bus.A == LAMP_R);
    b_ok      = ((bus.B == LAMP_G) || (bus.B == LAMP_Y) || (bus.B == LAMP_R)) &&
                ((bus.B == LAMP_G) || (bus.B == bus.A));
    a_changed = (bus.A != a_q);
    succ      = 3'b000;
    t_cur     = CNT_MAX;
    case (a_q)
      LAMP_G: begin succ = LAMP_Y; t_cur = TV; end
      LAMP_Y: begin succ = LAMP_R; t_cur = TA; end
      LAMP_R: begin succ = LAMP_G; t_cur = TR; end
      default: begin succ = 3'b000; t_cur = CNT_MAX; end
    endcase
  end

  // Prioritised violation code; sequence/dwell checks only apply while locked.
  always_comb begin
    viol = 3'd0;
    if (!a_onehot) begin
      viol = 3'd1;
    end else if (!b_ok) begin
      viol = 3'd5;
    end else if (state_q == TRACK) begin
      if (a_changed && (bus.A != succ)) begin
        viol = 3'd2;
      end else if (a_changed && (cnt_q < t_cur)) begin
        viol = 3'd3;
      end else if (!a_changed && (cnt_q == t_cur)) begin
        viol = 3'd4;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    cnt_d      = cnt_q;
    fault_d    = fault_q;
    code_d     = code_q;
    tracking_d = tracking_q;
    cycle_d    = cycle_q;

    case (state_q)
      SYNC: begin
        if (viol != 3'd0) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          code_d     = viol;
          tracking_d = 1'b0;
        end else if (a_q == 3'b000) begin
          a_d   = bus.A;
          cnt_d = {{(CW-1){1'b0}}, 1'b1};
        end else if (a_changed) begin
          // Illegal successors simply re-seed the lock attempt.
          if (bus.A == succ) begin
            state_d    = TRACK;
            tracking_d = 1'b1;
          end
          a_d   = bus.A;
          cnt_d = {{(CW-1){1'b0}}, 1'b1};
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      TRACK: begin
        if (viol != 3'd0) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          code_d     = viol;
          tracking_d = 1'b0;
        end else if (a_changed) begin
          // Only a legal change at exactly T(a_q) survives the checks above.
          if ((a_q == LAMP_R) && (cycle_q != 8'hFF)) begin
            cycle_d = cycle_q + 8'd1;
          end
          a_d   = bus.A;
          cnt_d = {{(CW-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FAULT: begin
        tracking_d = 1'b0;
        if (bus.clr) begin
          state_d = SYNC;
          fault_d = 1'b0;
          code_d  = 3'b000;
          a_d     = 3'b000;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d    = SYNC;
        a_d        = 3'b000;
        cnt_d      = '0;
        tracking_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SYNC;
      a_q        <= 3'b000;
      cnt_q      <= '0;
      fault_q    <= 1'b0;
      code_q     <= 3'b000;
      tracking_q <= 1'b0;
      cycle_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
      tracking_q <= tracking_d;
      cycle_q    <= cycle_d;
    end
  end

  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
  assign bus.tracking   = tracking_q;
  assign bus.cycle_cnt  = cycle_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench for semaforo_monitor: a behavioural model pushes the
// expected {fault, fault_code, tracking, cycle_cnt} for every driven sample,
// and each scenario task drains and compares against the captured outputs.
module tb_semaforo_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  semaforo_monitor_if bus ();

  semaforo_monitor #(
    .T_VERDE(2), .T_AMARELO(4), .T_VERMELHO(3), .CW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];

  // behavioural model state: 0 sync, 1 track, 2 fault
  int         m_state;
  logic [2:0] m_a;
  int         m_cnt;
  logic       m_fault;
  logic [2:0] m_code;
  logic       m_trk;
  int         m_cyc;

  function automatic bit oh(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic logic [2:0] nxt(input logic [2:0] v);
    if (v == 3'b001) return 3'b010;
    if (v == 3'b010) return 3'b100;
    if (v == 3'b100) return 3'b001;
    return 3'b111;
  endfunction

  function automatic int tdw(input logic [2:0] v);
    if (v == 3'b001) return 2;
    if (v == 3'b010) return 4;
    return 3;
  endfunction

  task automatic model_reset();
    m_state = 0; m_a = 3'b000; m_cnt = 0;
    m_fault = 1'b0; m_code = 3'b000; m_trk = 1'b0; m_cyc = 0;
  endtask

  task automatic model_step(input logic [2:0] a, input logic [2:0] b, input logic c);
    logic [2:0] code;
    if (m_state == 2) begin
      m_trk = 1'b0;
      if (c) begin
        m_state = 0; m_fault = 1'b0; m_code = 3'b000; m_a = 3'b000; m_cnt = 0;
      end
    end else begin
      code = 3'd0;
      if (!oh(a)) code = 3'd1;
      else if (!oh(b) || (b != 3'b001 && b != a)) code = 3'd5;
      else if (m_state == 1) begin
        if (a != m_a && a != nxt(m_a)) code = 3'd2;
        else if (a != m_a && m_cnt < tdw(m_a)) code = 3'd3;
        else if (a == m_a && m_cnt == tdw(m_a)) code = 3'd4;
      end
      if (code != 3'd0) begin
        m_state = 2; m_fault = 1'b1; m_code = code; m_trk = 1'b0;
      end else if (m_state == 0) begin
        if (m_a == 3'b000) begin
          m_a = a; m_cnt = 1;
        end else if (a != m_a) begin
          if (a == nxt(m_a)) begin m_state = 1; m_trk = 1'b1; end
          m_a = a; m_cnt = 1;
        end else if (m_cnt < 15) begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        if (a != m_a) begin
          if (m_a == 3'b100 && m_cyc < 255) m_cyc = m_cyc + 1;
          m_a = a; m_cnt = 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    exp_q.push_back({m_fault, m_code, m_trk, m_cyc[7:0]});
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic c);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.clr = c;
    model_step(a, b, c);
    @(posedge clk);
    #1;
    obs_q.push_back({bus.fault, bus.fault_code, bus.tracking, bus.cycle_cnt});
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.A = 3'b001; bus.B = 3'b001; bus.clr = 1'b0;
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic run_periods(input int n);
    for (int p = 0; p < n; p++) begin
      repeat (2) drive(3'b001, 3'b001, 1'b0);
      repeat (4) drive(3'b010, 3'b001, 1'b0);
      repeat (3) drive(3'b100, 3'b001, 1'b0);
    end
  endtask

  task automatic test_reset();
    logic [12:0] e, o;
    do_reset();
    #1;
    n_cmp++;
    if ({bus.fault, bus.fault_code, bus.tracking, bus.cycle_cnt} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0000", {bus.fault, bus.fault_code, bus.tracking, bus.cycle_cnt});
    end
    drive(3'b001, 3'b001, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL reset_seq: got %h want %h", o, e); end
    end
  endtask

  task automatic test_legal_sequence();
    logic [12:0] e, o;
    do_reset();
    run_periods(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL legal_seq: got %h want %h", o, e); end
    end
    n_cmp++;
    if (bus.cycle_cnt !== 8'd3 || bus.tracking !== 1'b1 || bus.fault !== 1'b0) begin
      n_err++;
      $display("FAIL legal_end: cyc=%0d trk=%b flt=%b want cyc=3 trk=1 flt=0", bus.cycle_cnt, bus.tracking, bus.fault);
    end
  endtask

  task automatic test_a_not_onehot();
    logic [12:0] e, o;
    drive(3'b001, 3'b001, 1'b0);
    drive(3'b011, 3'b001, 1'b0);
    drive(3'b001, 3'b001, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL a_onehot: got %h want %h", o, e); end
    end
    n_cmp++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd1 || bus.tracking !== 1'b0) begin
      n_err++;
      $display("FAIL a_onehot_code: flt=%b code=%0d trk=%b want 1/1/0", bus.fault, bus.fault_code, bus.tracking);
    end
  endtask

  task automatic test_illegal_successor_clr();
    logic [12:0] e, o;
    do_reset();
    run_periods(1);
    repeat (2) drive(3'b001, 3'b001, 1'b0);
    drive(3'b100, 3'b001, 1'b0);
    n_cmp++;
    if (bus.fault_code !== 3'd2 || bus.fault !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_succ: flt=%b code=%0d want 1/2", bus.fault, bus.fault_code);
    end
    drive(3'b001, 3'b001, 1'b1);
    n_cmp++;
    if (bus.fault !== 1'b0 || bus.tracking !== 1'b0 || bus.fault_code !== 3'd0) begin
      n_err++;
      $display("FAIL clr: flt=%b trk=%b code=%0d want 0/0/0", bus.fault, bus.tracking, bus.fault_code);
    end
    drive(3'b001, 3'b001, 1'b0);
    drive(3'b010, 3'b001, 1'b0);
    n_cmp++;
    if (bus.tracking !== 1'b1) begin
      n_err++;
      $display("FAIL resync: trk=%b want 1", bus.tracking);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL illegal_clr_seq: got %h want %h", o, e); end
    end
  endtask

  task automatic test_early_late();
    logic [12:0] e, o;
    do_reset();
    repeat (2) drive(3'b001, 3'b001, 1'b0);
    repeat (3) drive(3'b010, 3'b001, 1'b0);
    drive(3'b100, 3'b001, 1'b0);
    n_cmp++;
    if (bus.fault_code !== 3'd3) begin
      n_err++;
      $display("FAIL early: code=%0d want 3", bus.fault_code);
    end
    do_reset();
    repeat (2) drive(3'b001, 3'b001, 1'b0);
    repeat (4) drive(3'b010, 3'b001, 1'b0);
    n_cmp++;
    if (bus.fault !== 1'b0) begin
      n_err++;
      $display("FAIL late_premature: flt=%b want 0", bus.fault);
    end
    drive(3'b010, 3'b001, 1'b0);
    n_cmp++;
    if (bus.fault_code !== 3'd4 || bus.fault !== 1'b1) begin
      n_err++;
      $display("FAIL late: flt=%b code=%0d want 1/4", bus.fault, bus.fault_code);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL early_late_seq: got %h want %h", o, e); end
    end
  endtask

  task automatic test_b_and_clr_priority();
    logic [12:0] e, o;
    do_reset();
    repeat (2) drive(3'b001, 3'b001, 1'b0);
    repeat (4) drive(3'b010, 3'b001, 1'b0);
    drive(3'b100, 3'b010, 1'b0);
    n_cmp++;
    if (bus.fault_code !== 3'd5) begin
      n_err++;
      $display("FAIL b_code: code=%0d want 5", bus.fault_code);
    end
    drive(3'b100, 3'b100, 1'b0);
    drive(3'b011, 3'b001, 1'b1);
    n_cmp++;
    if (bus.fault !== 1'b0 || bus.fault_code !== 3'd0) begin
      n_err++;
      $display("FAIL clr_wins: flt=%b code=%0d want 0/0", bus.fault, bus.fault_code);
    end
    drive(3'b100, 3'b100, 1'b0);
    drive(3'b001, 3'b001, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL b_clr_seq: got %h want %h", o, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] e, o;
    do_reset();
    run_periods(2);
    repeat (2) drive(3'b001, 3'b001, 1'b0);
    repeat (2) drive(3'b010, 3'b001, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL pre_async: got %h want %h", o, e); end
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (bus.fault !== 1'b0 || bus.tracking !== 1'b0 || bus.cycle_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL async_rst: flt=%b trk=%b cyc=%0d want 0/0/0", bus.fault, bus.tracking, bus.cycle_cnt);
    end
    #1;
    rst = 1'b0;
    repeat (2) drive(3'b001, 3'b001, 1'b0);
    drive(3'b010, 3'b001, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL post_async: got %h want %h", o, e); end
    end
  endtask

  task automatic test_saturation();
    logic [12:0] e, o;
    do_reset();
    run_periods(260);
    drive(3'b001, 3'b001, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL sat_seq: got %h want %h", o, e); end
    end
    n_cmp++;
    if (bus.cycle_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL saturation: cyc=%0d want 255", bus.cycle_cnt);
    end
  endtask

  initial begin
    bus.A = 3'b000; bus.B = 3'b001; bus.clr = 1'b0;
    model_reset();
    test_reset();
    test_legal_sequence();
    test_a_not_onehot();
    test_illegal_successor_clr();
    test_early_late();
    test_b_and_clr_priority();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
